// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp/funct3 encodings and sequencer FSM states.
package alu_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  // Overflow is only meaningful for the arithmetic codes.
  function automatic logic ovf_applies(input logic [3:0] ctl);
    return (ctl == CTL_ADD) || (ctl == CTL_SUB);
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Purpose: map {alu_op, funct3, funct7_5} to a 4-bit ALU control code plus illegal flag.
// Latency: combinational.
// Backpressure: none.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = CTL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: ctl = CTL_ADD;
      ALUOP_SUB: ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD_SUB: ctl = funct7_5 ? CTL_SUB : CTL_ADD;
          F3_AND:     ctl = CTL_AND;
          F3_OR:      ctl = CTL_OR;
          F3_SLT:     ctl = CTL_SLT;
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: accept one ALU request, drive the ALU for one EXEC cycle, return result on rsp channel.
// Latency: response valid 2 cycles after request accept (legal), 1 cycle (illegal).
// Backpressure: req_ready low while a transaction is in flight; response held until rsp_ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int          CNT_W          = 16,
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_alu_op,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7_5,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t state;
  logic [3:0] dec_ctl;
  logic       dec_illegal;

  alu_ctl_decode u_decode (
    .alu_op   (req_alu_op),
    .funct3   (req_funct3),
    .funct7_5 (req_funct7_5),
    .ctl      (dec_ctl),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctl      <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (dec_illegal) begin
              // Skip the ALU entirely so its inputs stay quiet on a bad decode.
              rsp_result   <= ILLEGAL_RESULT;
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_illegal  <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= ST_RESP;
            end else begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_ctl <= dec_ctl;
              state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow & ovf_applies(alu_ctl);
          rsp_illegal  <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU on the alu_* ports.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int          CW  = 4;
  localparam logic [31:0] ILL = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [1:0]    req_alu_op;
  logic [2:0]    req_funct3;
  logic          req_funct7_5;
  logic [31:0]   req_a, req_b;
  logic [31:0]   alu_a, alu_b;
  logic [3:0]    alu_ctl;
  logic [31:0]   alu_result;
  logic          alu_zero, alu_overflow;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_result;
  logic          rsp_zero, rsp_overflow, rsp_illegal;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CNT_W(CW), .ILLEGAL_RESULT(ILL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  // Behavioural ALU; overflow is driven for every code so the DUT's masking is visible.
  logic [31:0] sum, diff;
  logic        ovf_add, ovf_sub;
  assign sum     = alu_a + alu_b;
  assign diff    = alu_a - alu_b;
  assign ovf_add = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
  assign ovf_sub = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = ovf_sub;
    case (alu_ctl)
      4'b0000: begin alu_result = alu_a & alu_b; alu_overflow = ovf_add; end
      4'b0001: begin alu_result = alu_a | alu_b; alu_overflow = ovf_add; end
      4'b0010: begin alu_result = sum;           alu_overflow = ovf_add; end
      4'b0110: alu_result = diff;
      4'b0111: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; DUT is expected to be idle and accept it on that edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_alu_op = op; req_funct3 = f3; req_funct7_5 = f7; req_a = a; req_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic exec_legal(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ectl, input logic [31:0] eres,
                            input logic ez, input logic eo);
    send(op, f3, f7, a, b);
    check({tag, "_ctl"}, {28'h0, alu_ctl}, {28'h0, ectl});
    check({tag, "_vld_exec"}, {31'h0, rsp_valid}, 32'h0);
    tick();
    check({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_res"}, rsp_result, eres);
    check({tag, "_zero"}, {31'h0, rsp_zero}, {31'h0, ez});
    check({tag, "_ovf"}, {31'h0, rsp_overflow}, {31'h0, eo});
    check({tag, "_ill"}, {31'h0, rsp_illegal}, 32'h0);
    drain();
  endtask

  initial begin
    logic [CW-1:0] cnt_before;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_alu_op = '0; req_funct3 = '0; req_funct7_5 = 1'b0; req_a = '0; req_b = '0;
    #2;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_count", {28'h0, op_count}, 32'h0);
    check("rst_alu_ctl", {28'h0, alu_ctl}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // Arithmetic / logic vectors
    exec_legal("add", 2'b10, 3'b000, 1'b0, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0, 1'b0);
    check("count1", {28'h0, op_count}, 32'h1);
    check("idle_rdy", {31'h0, req_ready}, 32'h1);
    exec_legal("sub_ovf", 2'b10, 3'b000, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
               4'b0110, 32'h8000_0000, 1'b0, 1'b1);
    exec_legal("slt", 2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h1, 1'b0, 1'b0);
    exec_legal("slt_mask", 2'b10, 3'b010, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
               4'b0111, 32'h0, 1'b1, 1'b0);
    exec_legal("beq", 2'b01, 3'b101, 1'b1, 32'h1234, 32'h1234, 4'b0110, 32'h0, 1'b1, 1'b0);
    exec_legal("and", 2'b10, 3'b111, 1'b1, 32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, 1'b0, 1'b0);
    exec_legal("or_mask", 2'b10, 3'b110, 1'b0, 32'h7FFF_FFFF, 32'h1,
               4'b0001, 32'h7FFF_FFFF, 1'b0, 1'b0);
    exec_legal("ldst", 2'b00, 3'b011, 1'b1, 32'h7FFF_FFFF, 32'h1,
               4'b0010, 32'h8000_0000, 1'b0, 1'b1);
    check("count8", {28'h0, op_count}, 32'h8);

    // Illegal decodes: response right after accept, ALU control untouched
    send(2'b10, 3'b001, 1'b0, 32'h55, 32'h66);
    check("ill_vld", {31'h0, rsp_valid}, 32'h1);
    check("ill_flag", {31'h0, rsp_illegal}, 32'h1);
    check("ill_res", rsp_result, ILL);
    check("ill_zero", {31'h0, rsp_zero}, 32'h0);
    check("ill_ovf", {31'h0, rsp_overflow}, 32'h0);
    check("ill_ctl", {28'h0, alu_ctl}, 32'h2);
    drain();
    send(2'b11, 3'b000, 1'b0, 32'h1, 32'h1);
    check("ill11_vld", {31'h0, rsp_valid}, 32'h1);
    check("ill11_flag", {31'h0, rsp_illegal}, 32'h1);
    drain();
    check("count10", {28'h0, op_count}, 32'hA);

    // Response backpressure with a competing request
    send(2'b00, 3'b000, 1'b0, 32'd3, 32'd4);
    tick();
    req_alu_op = 2'b01; req_a = 32'd100; req_b = 32'd1; req_valid = 1'b1;
    cnt_before = op_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld", {31'h0, rsp_valid}, 32'h1);
      check("bp_res", rsp_result, 32'd7);
      check("bp_rdy", {31'h0, req_ready}, 32'h0);
      check("bp_alu_a", alu_a, 32'd3);
      check("bp_count", {28'h0, op_count}, {28'h0, cnt_before});
    end
    req_valid = 1'b0;
    drain();
    check("bp_count_inc", {28'h0, op_count}, {28'h0, cnt_before + CW'(1)});
    tick(); tick();
    check("bp_not_buffered", {31'h0, rsp_valid}, 32'h0);
    check("bp_alu_a_kept", alu_a, 32'd3);

    // Reset while in EXEC drops the transaction
    send(2'b00, 3'b000, 1'b0, 32'd9, 32'd9);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_count", {28'h0, op_count}, 32'h0);
    check("mid_rst_ctl", {28'h0, alu_ctl}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_vld", {31'h0, rsp_valid}, 32'h0);
    end

    // Counter wrap at 2^CW
    for (int i = 0; i < 15; i++)
      exec_legal("wrap", 2'b00, 3'b000, 1'b0, i, 32'd1, 4'b0010, i + 1, 1'b0, 1'b0);
    check("count15", {28'h0, op_count}, 32'hF);
    exec_legal("wrap16", 2'b10, 3'b110, 1'b0, 32'h0, 32'h0, 4'b0001, 32'h0, 1'b1, 1'b0);
    check("count_wrap", {28'h0, op_count}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
